// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for the CPU's single-port data memory.
// Requester 0 is the CPU memory stage, requester 1 is the debug/dump port.
// One transaction at a time: grant -> ACCESS (1 cycle, mem_en) -> RESP (ack).
// Ports:
//   CLK, rst                       clock, async active-low reset
//   cpu_req/we/addr/wdata          CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack, cpu_stall  CPU response, stall while request pending
//   dbg_req/we/addr/wdata          debug request (level, held until dbg_ack)
//   dbg_rdata, dbg_ack             debug response
//   mem_en/we/addr/wdata           synchronous memory port strobes
//   mem_rdata                      memory read data, valid cycle after mem_en
//   busy                           arbiter not idle
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DBG = 1'b1;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              cpu_cand;
    logic              dbg_cand;
    logic              grant;
    logic              pick;

    // State and latched-transaction registers
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= SEL_DBG;   // CPU wins the first tie
            owner_q <= SEL_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state, round-robin arbitration and request latching
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cpu_cand = 1'b0;
        dbg_cand = 1'b0;
        grant    = 1'b0;
        pick     = SEL_CPU;

        case (state_q)
            IDLE: begin
                cpu_cand = cpu_req;
                dbg_cand = dbg_req;
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                // The requester being acked still holds req this cycle
                cpu_cand = cpu_req & (owner_q != SEL_CPU);
                dbg_cand = dbg_req & (owner_q != SEL_DBG);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cpu_cand && dbg_cand) begin
            grant = 1'b1;
            pick  = (last_q == SEL_CPU) ? SEL_DBG : SEL_CPU;
        end else if (cpu_cand) begin
            grant = 1'b1;
            pick  = SEL_CPU;
        end else if (dbg_cand) begin
            grant = 1'b1;
            pick  = SEL_DBG;
        end

        if (grant) begin
            state_d = ACCESS;
            last_d  = pick;
            owner_d = pick;
            if (pick == SEL_CPU) begin
                we_d    = cpu_we;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
            end else begin
                we_d    = dbg_we;
                addr_d  = dbg_addr;
                wdata_d = dbg_wdata;
            end
        end
    end

    // Memory port: driven only during ACCESS, from the latch
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    // Response: mem_rdata arrives in RESP, routed only to the owner on reads
    assign cpu_ack   = (state_q == RESP) && (owner_q == SEL_CPU);
    assign dbg_ack   = (state_q == RESP) && (owner_q == SEL_DBG);
    assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : '0;
    assign dbg_rdata = (dbg_ack && !we_q) ? mem_rdata : '0;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level reference (memory contents array, latency bounds, ack rules).
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    logic              CLK = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              dbg_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;

    logic [DATA_W-1:0] mem     [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];

    int tests  = 0;
    int failed = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read single-port memory, 1-cycle read latency
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction from an idle arbiter: expects ack 2 cycles after the request
    task automatic txn(input bit who, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
        int lat = 0;
        int ens = 0;
        bit got = 1'b0;
        if (who == 1'b0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end
        for (int n = 1; n <= 8 && !got; n++) begin
            tick();
            if (mem_en) ens++;
            if ((who == 1'b0 && cpu_ack) || (who == 1'b1 && dbg_ack)) begin
                got = 1'b1;
                lat = n;
            end
            if (who == 1'b0) chk({tag, "_stall"}, 32'(cpu_stall), 32'(!got));
        end
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_men"}, 32'(ens), 32'd1);
        if (got) begin
            if (who == 1'b0) begin
                chk({tag, "_rd"},  32'(cpu_rdata), 32'(exp_rd));
                chk({tag, "_ord"}, 32'(dbg_rdata), 32'd0);
            end else begin
                chk({tag, "_rd"},  32'(dbg_rdata), 32'(exp_rd));
                chk({tag, "_ord"}, 32'(cpu_rdata), 32'd0);
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int lat;
        bit cp, dp;
        int cs, ds;
        bit pmen, pwe;
        logic [7:0]  pa;
        logic [15:0] pd;

        // Reset with cpu_req held high
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'h0008;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
        #12;
        chk("rst_outs", 32'({cpu_ack, dbg_ack, mem_en, mem_we, busy}), 32'd0);
        chk("rst_bus",  32'({mem_addr, mem_wdata, cpu_rdata, dbg_rdata}), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("t1_access", 32'({mem_en, mem_we, busy, cpu_ack, cpu_stall}), 32'b11101);
        chk("t1_maddr", 32'(mem_addr), 32'h05);
        chk("t1_mdata", 32'(mem_wdata), 32'h0008);
        tick();
        chk("t1_ack", 32'({cpu_ack, dbg_ack, mem_en, cpu_stall}), 32'b1000);
        chk("t1_wrd", 32'(cpu_rdata), 32'd0);
        cpu_req = 1'b0;
        tick();
        chk("t1_idle", 32'({busy, cpu_ack, mem_en}), 32'd0);

        // CPU reads back its own write
        txn(1'b0, 1'b0, 8'h05, 16'h0000, 16'h0008, "t2");

        // Both requesting out of reset: strict alternation, acks 2 cycles apart
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h05;
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t3_busy", 32'(busy), 32'd1);
            chk("t3_cack", 32'(cpu_ack), 32'((k % 4) == 2));
            chk("t3_dack", 32'(dbg_ack), 32'((k % 4) == 0));
            if (cpu_ack) chk("t3_crd", 32'(cpu_rdata), 32'h0008);
            if (dbg_ack) chk("t3_drd", 32'(dbg_rdata), 32'h0008);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        tick();
        chk("t3_idle", 32'(busy), 32'd0);

        // CPU fills 0..15 with i*3, debug port dumps it back
        for (int i = 0; i < 16; i++) begin
            txn(1'b0, 1'b1, 8'(i), 16'(i * 3), 16'h0000, "t4w");
            ref_mem[i] = 16'(i * 3);
        end
        for (int i = 0; i < 16; i++)
            txn(1'b1, 1'b0, 8'(i), 16'h0000, ref_mem[i], "t4r");

        // cpu_req dropped (and address changed) during ACCESS
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03;
        tick();
        chk("t5_access", 32'({mem_en, mem_addr}), 32'({1'b1, 8'h03}));
        cpu_req = 1'b0; cpu_addr = 8'hAA;
        tick();
        chk("t5_ack", 32'({cpu_ack, cpu_stall}), 32'b10);
        chk("t5_rd", 32'(cpu_rdata), 32'd9);
        tick();
        chk("t5_idle", 32'({busy, cpu_ack, mem_en}), 32'd0);

        // Reset during ACCESS: mem_en drops at once, no ack follows
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 16'h1234;
        tick();
        chk("t6_access", 32'({mem_en, mem_we}), 32'b11);
        #2 rst = 1'b0;
        #1;
        chk("t6_async", 32'({mem_en, busy}), 32'd0);
        tick();
        chk("t6_noack", 32'({dbg_ack, cpu_ack, mem_en, busy}), 32'd0);
        dbg_req = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_idle", 32'(busy), 32'd0);

        // Randomized traffic against the reference memory
        cyc = 0; cp = 1'b0; dp = 1'b0; cs = 0; ds = 0;
        pmen = mem_en; pwe = mem_we; pa = mem_addr; pd = mem_wdata;
        for (int c = 0; c < 600; c++) begin
            tick();
            cyc++;
            chk("rnd_excl", 32'(cpu_ack & dbg_ack), 32'd0);
            chk("rnd_stall", 32'(cpu_stall), 32'(cpu_req & ~cpu_ack));
            if (mem_en) chk("rnd_en_ack", 32'(cpu_ack | dbg_ack), 32'd0);
            if (cpu_ack) begin
                lat = cyc - cs;
                chk("rnd_cpu_pend", 32'(cp), 32'd1);
                chk("rnd_cpu_acc", 32'({pmen, pwe, pa}), 32'({1'b1, cpu_we, cpu_addr}));
                if (cpu_we) chk("rnd_cpu_wd", 32'(pd), 32'(cpu_wdata));
                chk("rnd_cpu_lat", 32'(lat >= 2 && lat <= 4), 32'd1);
                chk("rnd_cpu_rd", 32'(cpu_rdata), cpu_we ? 32'd0 : 32'(ref_mem[cpu_addr]));
                chk("rnd_cpu_ord", 32'(dbg_rdata), 32'd0);
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                cp = 1'b0;
                cpu_req = 1'b0;
            end
            if (dbg_ack) begin
                lat = cyc - ds;
                chk("rnd_dbg_pend", 32'(dp), 32'd1);
                chk("rnd_dbg_acc", 32'({pmen, pwe, pa}), 32'({1'b1, dbg_we, dbg_addr}));
                if (dbg_we) chk("rnd_dbg_wd", 32'(pd), 32'(dbg_wdata));
                chk("rnd_dbg_lat", 32'(lat >= 2 && lat <= 4), 32'd1);
                chk("rnd_dbg_rd", 32'(dbg_rdata), dbg_we ? 32'd0 : 32'(ref_mem[dbg_addr]));
                chk("rnd_dbg_ord", 32'(cpu_rdata), 32'd0);
                if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
                dp = 1'b0;
                dbg_req = 1'b0;
            end
            pmen = mem_en; pwe = mem_we; pa = mem_addr; pd = mem_wdata;
            if (c < 580) begin
                if (!cp && !cpu_ack && $urandom_range(0, 2) == 0) begin
                    cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 8'($urandom_range(0, 15));
                    cpu_wdata = 16'($urandom);
                    cpu_req = 1'b1; cp = 1'b1; cs = cyc;
                end
                if (!dp && !dbg_ack && $urandom_range(0, 2) == 0) begin
                    dbg_we = 1'($urandom_range(0, 1));
                    dbg_addr = 8'($urandom_range(0, 15));
                    dbg_wdata = 16'($urandom);
                    dbg_req = 1'b1; dp = 1'b1; ds = cyc;
                end
            end
        end
        chk("rnd_drain_cpu", 32'(cp), 32'd0);
        chk("rnd_drain_dbg", 32'(dp), 32'd0);
        chk("rnd_end_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter for the single-port data memory of the 16-bit CPU.
- Requester 0 is the CPU memory stage; requester 1 is the debug/dump port (memory inspection after halt, preload before run).
- Grants one transaction at a time and sequences the synchronous-read memory (1-cycle read latency).
- Returns read data and a one-cycle ack to the granted requester, and raises a stall to the CPU while its request is pending.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 16, memory data width

Ports:
CLK  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack
dbg_req  in  1  debug request, level, held until dbg_ack
dbg_we  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  read data, valid when dbg_ack=1
dbg_ack  out  1  one-cycle completion pulse
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, only meaningful with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, registered, valid the cycle after mem_en
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=DBG (so the CPU wins the first tie), all latched request regs cleared.
  - All outputs 0; cpu_stall follows cpu_req.
- States: IDLE, ACCESS, RESP.
- Arbitration runs at the rising edge in IDLE and in RESP:
  - Exactly one requester in the arbitration set: grant it.
  - Both requesting: grant the one that is not last_grant (round-robin); update last_grant on every grant.
  - On a grant, latch owner, we, addr, wdata; next state ACCESS.
- Arbitration set in RESP excludes the requester being acked this cycle (its req is still high).
- IDLE with no request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_en=1, mem_we/mem_addr/mem_wdata from the latched regs.
  - Next state RESP.
  - Address and data are taken from the latch; requester input changes during ACCESS have no effect.
- RESP (exactly 1 cycle):
  - Owner's ack=1; owner's rdata=mem_rdata for a read, 0 for a write; the non-owner's rdata=0.
  - Next state: ACCESS if a new grant is made (arbitrated as above), else IDLE.
- Latency:
  - Request sampled at edge k → ACCESS during cycle k+1 → ack in cycle k+2.
  - Back-to-back throughput: one transaction per 2 cycles.
- Both requesters continuously active: grants strictly alternate CPU, DBG, CPU, …; neither starves.
- Requester drops req before ack: the latched transaction still completes and ack is still pulsed; no abort.
- Write then read of the same address (either order, either requester): the read returns the written value, because accesses are serialised.
- Reset asserted mid-ACCESS: mem_en drops immediately; whether that write lands is undefined; no ack is issued.
- Address wrap: none; ADDR_W bits passed through unchanged.
- cpu_ack and dbg_ack are never high in the same cycle; mem_en is never high in RESP or IDLE.

Test Plan:
- Reset with cpu_req=1: all outputs 0, cpu_stall=1; first edge after release grants CPU; cpu_ack in the 2nd cycle after that.
- CPU write addr 0x05 data 0x0008, then CPU read 0x05 → cpu_rdata=0x0008 with cpu_ack; mem_en high exactly one cycle per access; cpu_stall low only in ack cycles.
- cpu_req and dbg_req both asserted from reset, 6 transactions → grant order CPU, DBG, CPU, DBG, CPU, DBG; acks 2 cycles apart; busy stays 1.
- DBG reads 0x00–0x0F after the CPU wrote value i*3 to address i → dbg_rdata returns i*3 for each address; cpu_rdata stays 0.
- cpu_req dropped during ACCESS → cpu_ack still pulses in RESP, then IDLE; rst pulled low during ACCESS → next cycle state IDLE, no ack, mem_en=0.
